pipe_ctrl_hazard: RTL and testbench

//  Carries the decoded control bundle from the control decoder (ID) down the
//  EX, MEM and WB pipeline registers. Detects load-use hazards, inserts bubbles
//  and squashes on an EX-stage redirect. Generates EX operand forwarding selects.

---
 rtl/pipe_ctrl_hazard.sv | 108 ++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_hazard.sv
// Control-bundle pipeline (ID->EX->MEM->WB) with load-use stall, EX-redirect squash,
// EX operand forwarding selects and saturating stall/flush event counters.
module pipe_ctrl_hazard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      id_ctrl,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic [10:0]      ex_ctrl,
    output logic [10:0]      mem_ctrl,
    output logic [10:0]      wb_ctrl,
    output logic [4:0]       ex_rd,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // ctrl bit positions: {branch,mr,mwrite,alusrc,regwr,aluop[1:0],mtoreg[1:0],jal,jalr}
    localparam int B_MR     = 9;
    localparam int B_MWRITE = 8;
    localparam int B_ALUSRC = 7;
    localparam int B_REGWR  = 6;
    localparam int B_JAL    = 1;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ex_stage_t;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [4:0]  rd;
    } late_stage_t;

    ex_stage_t   ex_q, ex_d;
    late_stage_t mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic load_use, uses_rs2, stall_ev;

    assign uses_rs2 = ~id_ctrl[B_ALUSRC] | id_ctrl[B_MWRITE];
    assign load_use = ex_q.ctrl[B_MR] & (ex_q.rd != 5'd0)
                    & ((ex_q.rd == id_rs1) | (uses_rs2 & (ex_q.rd == id_rs2)))
                    & ~id_ctrl[B_JAL];
    assign stall_ev = load_use & ~ex_redirect;

    // Gated by rst_n so a redirect seen during reset cannot leak onto the hazard lines.
    assign flush_ifid = rst_n & ex_redirect;
    assign stall_pc   = rst_n & stall_ev;
    assign stall_ifid = rst_n & stall_ev;

    always_comb begin
        ex_d = '{ctrl: id_ctrl, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
        if (ex_redirect || load_use)
            ex_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{ctrl: ex_q.ctrl, rd: ex_q.rd};
            wb_q  <= mem_q;
            if (stall_ev && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (ex_redirect && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input late_stage_t mem_s,
                                           input late_stage_t wb_s);
        if (mem_s.ctrl[B_REGWR] && (mem_s.rd != 5'd0) && (mem_s.rd == rs))
            return 2'b10;
        else if (wb_s.ctrl[B_REGWR] && (wb_s.rd != 5'd0) && (wb_s.rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);

    assign ex_ctrl   = ex_q.ctrl;
    assign mem_ctrl  = mem_q.ctrl;
    assign wb_ctrl   = wb_q.ctrl;
    assign ex_rd     = ex_q.rd;
    assign mem_rd    = mem_q.rd;
    assign wb_rd     = wb_q.rd;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Self-checking bench for pipe_ctrl_hazard; a second instance with CNT_W=2 covers saturation.
module tb_pipe_ctrl_hazard;
    localparam logic [10:0] LW   = 11'b0_1_0_1_1_00_01_0_0;
    localparam logic [10:0] ADD  = 11'b0_0_0_0_1_10_00_0_0;
    localparam logic [10:0] ADDI = 11'b0_0_0_1_1_10_00_0_0;
    localparam logic [10:0] SW   = 11'b0_0_1_1_0_00_00_0_0;
    localparam logic [10:0] BEQ  = 11'b1_0_0_0_0_01_00_0_0;
    localparam logic [10:0] NOP  = 11'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] id_ctrl = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        ex_redirect = 1'b0;

    logic stall_pc, stall_ifid, flush_ifid;
    logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_stall_pc, s_stall_ifid, s_flush_ifid;
    logic [10:0] s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
    logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl_hazard #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_redirect(ex_redirect), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .flush_ifid(flush_ifid), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    pipe_ctrl_hazard #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_redirect(ex_redirect), .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid),
        .flush_ifid(s_flush_ifid), .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
        .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] c, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic redir);
        id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_redirect = redir;
        #1;
    endtask

    task automatic do_reset();
        drive(NOP, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(BEQ, 1, 2, 0, 1); exp_flush++;
        tick();
        drive(ADD, 1, 2, 3, 0); tick();
        drive(LW, 1, 0, 5, 0);  tick();
        drive(ADD, 5, 6, 7, 0);
        checks++;
        if (flush_cnt !== 16'(exp_flush)) begin
            errors++; $display("FAIL pre_reset_flush_cnt: got %0d exp %0d", flush_cnt, exp_flush);
        end
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall: got %b exp 1", stall_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd} !== 48'd0) begin
            errors++; $display("FAIL reset_stages: got %h exp 0", {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd});
        end
        checks++;
        if ({stall_cnt, flush_cnt, fwd_a, fwd_b} !== 36'd0) begin
            errors++; $display("FAIL reset_cnt_fwd: got %h exp 0", {stall_cnt, flush_cnt, fwd_a, fwd_b});
        end
        checks++;
        if ({stall_pc, stall_ifid, flush_ifid} !== 3'b000) begin
            errors++; $display("FAIL reset_hazard: got %b exp 000", {stall_pc, stall_ifid, flush_ifid});
        end
        tick();
        drive(NOP, 0, 0, 0, 0);
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use();
        drive(LW, 1, 0, 5, 0); tick();
        drive(ADD, 5, 6, 7, 0);
        checks++;
        if ({stall_pc, stall_ifid, flush_ifid} !== 3'b110) begin
            errors++; $display("FAIL lu_hazard: got %b exp 110", {stall_pc, stall_ifid, flush_ifid});
        end
        exp_stall++;
        tick();
        checks++;
        if (ex_ctrl !== NOP || stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL lu_bubble: got ex_ctrl %h cnt %0d exp 0 cnt %0d", ex_ctrl, stall_cnt, exp_stall);
        end
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL lu_one_cycle: got %b exp 0", stall_pc);
        end
        tick();
        checks++;
        if (ex_ctrl !== ADD || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL lu_fwd: got ctrl %h a %b b %b exp %h 01 00", ex_ctrl, fwd_a, fwd_b, ADD);
        end
    endtask

    task automatic test_store_hazard();
        drive(LW, 1, 0, 5, 0); tick();
        drive(SW, 2, 5, 0, 0);
        checks++;
        if (stall_pc !== 1'b1 || stall_ifid !== 1'b1) begin
            errors++; $display("FAIL sw_stall: got %b%b exp 11", stall_pc, stall_ifid);
        end
        exp_stall++;
        tick();
        drive(LW, 1, 0, 5, 0); tick();
        drive(ADDI, 2, 5, 8, 0);
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL addi_nostall: got %b exp 0", stall_pc);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL sw_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_redirect_priority();
        drive(LW, 1, 0, 5, 0); tick();
        drive(ADD, 5, 6, 7, 1);
        checks++;
        if ({stall_pc, stall_ifid, flush_ifid} !== 3'b001) begin
            errors++; $display("FAIL redir_hazard: got %b exp 001", {stall_pc, stall_ifid, flush_ifid});
        end
        exp_flush++;
        tick();
        checks++;
        if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL redir_cnt: got f %0d s %0d exp f %0d s %0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
        checks++;
        if (ex_ctrl !== NOP || mem_ctrl !== LW) begin
            errors++; $display("FAIL redir_bubble: got ex %h mem %h exp 0 %h", ex_ctrl, mem_ctrl, LW);
        end
        drive(NOP, 0, 0, 0, 0);
    endtask

    task automatic test_forward();
        drive(ADD, 1, 2, 7, 0); tick();
        drive(ADD, 1, 2, 7, 0); tick();
        drive(ADD, 7, 7, 8, 0); tick();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_prio: got %b %b exp 10 10", fwd_a, fwd_b);
        end
        drive(ADD, 1, 2, 9, 0); tick();
        drive(NOP, 0, 0, 0, 0); tick();
        drive(ADD, 3, 9, 4, 0); tick();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_wb: got %b %b exp 00 01", fwd_a, fwd_b);
        end
        drive(ADD, 1, 2, 0, 0); tick();
        drive(ADD, 1, 2, 0, 0); tick();
        drive(ADD, 0, 0, 4, 0); tick();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_x0: got %b %b exp 00 00", fwd_a, fwd_b);
        end
        drive(NOP, 0, 0, 0, 0); tick();
    endtask

    task automatic test_pipeline();
        logic [10:0] c;
        logic [4:0]  rd;
        logic [15:0] e;
        sb_q.delete();
        for (int i = 0; i < 16; i++) begin
            c  = 11'($urandom) & ~11'h200;
            rd = 5'($urandom);
            drive(c, 5'($urandom), 5'($urandom), rd, 0);
            sb_q.push_back({c, rd});
            tick();
            if (sb_q.size() == 3) begin
                e = sb_q.pop_front();
                checks++;
                if ({wb_ctrl, wb_rd} !== e) begin
                    errors++; $display("FAIL pipe_wb[%0d]: got %h exp %h", i, {wb_ctrl, wb_rd}, e);
                end
            end
        end
        drive(NOP, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        do_reset();
        exp_s = 2'd0;
        for (int i = 0; i < 5; i++) begin
            drive(LW, 1, 0, 5, 0); tick();
            drive(ADD, 5, 6, 7, 0);
            exp_stall++;
            exp_s = (exp_s == 2'd3) ? 2'd3 : exp_s + 2'd1;
            tick();
            checks++;
            if (s_stall_cnt !== exp_s) begin
                errors++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, s_stall_cnt, exp_s);
            end
        end
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL wide_cnt: got %0d exp %0d", stall_cnt, exp_stall);
        end
        drive(NOP, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store_hazard();
        test_redirect_priority();
        test_forward();
        test_pipeline();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
